// File: rtl/display_timing_pkg.sv
// Shared 640x480 @ 60 Hz raster constants and 12-bit colour values for the display pipeline.
// Controllers import this instead of hard-coding window edges.
package display_timing_pkg;

  localparam int unsigned HTotal     = 800;
  localparam int unsigned HSync      = 96;
  localparam int unsigned HActStart  = 144;
  localparam int unsigned HActEnd    = 783;
  localparam int unsigned VTotal     = 525;
  localparam int unsigned VSync      = 2;
  localparam int unsigned VActStart  = 35;
  localparam int unsigned VActEnd    = 514;
  localparam int unsigned PixClkDiv  = 4;

  typedef logic [9:0]  coord_t;
  typedef logic [11:0] rgb_t;

  localparam rgb_t Black = 12'h000;
  localparam rgb_t White = 12'hFFF;
  localparam rgb_t Red   = 12'hF00;
  localparam rgb_t Green = 12'h0F0;

  function automatic logic in_range(input coord_t x, input coord_t lo, input coord_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// Raster bus from the timing generator to the block/sprite controllers.
interface display_timing_gen_if;
  import display_timing_pkg::*;

  logic   pix_en;
  coord_t hCount;
  coord_t vCount;
  logic   hSync;
  logic   vSync;
  logic   bright;
  logic   frame_tick;

  modport master (output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick);
  modport slave  (input  pix_en, hCount, vCount, hSync, vSync, bright, frame_tick);
endinterface

// File: rtl/pix_clk_en.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV system clocks, decoded from the divider register.
module pix_clk_en #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] DivMax = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + W'(1);
    if (div_cnt_q == DivMax) div_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  assign pix_en = (div_cnt_q == DivMax);

endmodule

// File: rtl/display_timing_gen.sv
// VGA raster timing: pixel-rate h/v counters with sync, visible-window and frame-tick decodes
// registered from the next-state counters so they always line up with hCount/vCount.
module display_timing_gen
  import display_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = PixClkDiv,
  parameter int unsigned H_TOTAL     = HTotal,
  parameter int unsigned H_SYNC      = HSync,
  parameter int unsigned H_ACT_START = HActStart,
  parameter int unsigned H_ACT_END   = HActEnd,
  parameter int unsigned V_TOTAL     = VTotal,
  parameter int unsigned V_SYNC      = VSync,
  parameter int unsigned V_ACT_START = VActStart,
  parameter int unsigned V_ACT_END   = VActEnd
) (
  input  logic                clk,
  input  logic                rst,
  display_timing_gen_if.master ras
);

  localparam coord_t HLast     = 10'(H_TOTAL - 1);
  localparam coord_t VLast     = 10'(V_TOTAL - 1);
  localparam coord_t HSyncW    = 10'(H_SYNC);
  localparam coord_t VSyncW    = 10'(V_SYNC);
  localparam coord_t HActLo    = 10'(H_ACT_START);
  localparam coord_t HActHi    = 10'(H_ACT_END);
  localparam coord_t VActLo    = 10'(V_ACT_START);
  localparam coord_t VActHi    = 10'(V_ACT_END);
  localparam coord_t VTickLine = 10'(V_ACT_END + 1);

  logic   pix_en;
  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   hsync_q, vsync_q, bright_q, frame_tick_q;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q          <= '0;
      v_q          <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      bright_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= (h_d >= HSyncW);
      vsync_q      <= (v_d >= VSyncW);
      bright_q     <= in_range(h_d, HActLo, HActHi) && in_range(v_d, VActLo, VActHi);
      // Only the stepping edge into (0, first blank line) fires, not the following idle clks.
      frame_tick_q <= pix_en && (h_d == '0) && (v_d == VTickLine);
    end
  end

  assign ras.pix_en     = pix_en;
  assign ras.hCount     = h_q;
  assign ras.vCount     = v_q;
  assign ras.hSync      = hsync_q;
  assign ras.vSync      = vsync_q;
  assign ras.bright     = bright_q;
  assign ras.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench: full-size instance for reset release and line timing, shrunken-raster
// instance (CLK_DIV = 2) for window edges, frames, frame_tick and mid-frame reset.
module tb_display_timing_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  display_timing_gen_if ras_a ();
  display_timing_gen_if ras_b ();

  display_timing_gen u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .ras (ras_a)
  );

  // 16x12 raster: sync 3/2, visible h 5..13, v 3..9 -> line 32 clks, frame 384 clks.
  display_timing_gen #(
    .CLK_DIV     (2),
    .H_TOTAL     (16),
    .H_SYNC      (3),
    .H_ACT_START (5),
    .H_ACT_END   (13),
    .V_TOTAL     (12),
    .V_SYNC      (2),
    .V_ACT_START (3),
    .V_ACT_END   (9)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .ras (ras_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // hCount, vCount, hSync, vSync, bright, frame_tick of instance B
  task automatic check_b(input string tag, input int h, input int v, input logic hs,
                         input logic vs, input logic br, input logic ft);
    check_val({tag, "_h"}, 32'(ras_b.hCount), 32'(h));
    check_val({tag, "_v"}, 32'(ras_b.vCount), 32'(v));
    check_val({tag, "_hs"}, 32'(ras_b.hSync), 32'(hs));
    check_val({tag, "_vs"}, 32'(ras_b.vSync), 32'(vs));
    check_val({tag, "_br"}, 32'(ras_b.bright), 32'(br));
    check_val({tag, "_ft"}, 32'(ras_b.frame_tick), 32'(ft));
  endtask

  initial begin
    int hs_low, pe_cnt, br_cnt, vs_low, ft_cnt, ft_first, ft_last;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) tick();

    check_val("a_rst_pix_en", 32'(ras_a.pix_en), 32'd0);
    check_val("a_rst_h", 32'(ras_a.hCount), 32'd0);
    check_val("a_rst_v", 32'(ras_a.vCount), 32'd0);
    check_val("a_rst_hs", 32'(ras_a.hSync), 32'd0);
    check_val("a_rst_vs", 32'(ras_a.vSync), 32'd0);
    check_val("a_rst_br", 32'(ras_a.bright), 32'd0);
    check_val("a_rst_ft", 32'(ras_a.frame_tick), 32'd0);

    // Full-size instance: release, first pixel steps, one full line.
    rst_a = 1'b0;
    hs_low = 0;
    pe_cnt = 0;
    br_cnt = 0;
    for (int k = 1; k <= 6400; k++) begin
      tick();
      case (k)
        1, 2: check_val("a_pix_en_early", 32'(ras_a.pix_en), 32'd0);
        3: begin
          check_val("a_pix_en_first", 32'(ras_a.pix_en), 32'd1);
          check_val("a_h_at3", 32'(ras_a.hCount), 32'd0);
        end
        4: begin
          check_val("a_pix_en_after", 32'(ras_a.pix_en), 32'd0);
          check_val("a_h_at4", 32'(ras_a.hCount), 32'd1);
          check_val("a_v_at4", 32'(ras_a.vCount), 32'd0);
          check_val("a_hs_at4", 32'(ras_a.hSync), 32'd0);
        end
        3199: begin
          check_val("a_h_line_end", 32'(ras_a.hCount), 32'd799);
          check_val("a_v_line_end", 32'(ras_a.vCount), 32'd0);
        end
        3200: begin
          check_val("a_h_wrap", 32'(ras_a.hCount), 32'd0);
          check_val("a_v_wrap", 32'(ras_a.vCount), 32'd1);
        end
        6400: begin
          check_val("a_h_wrap2", 32'(ras_a.hCount), 32'd0);
          check_val("a_v_wrap2", 32'(ras_a.vCount), 32'd2);
        end
        default: ;
      endcase
      if (k >= 3200 && k <= 6399) begin
        if (!ras_a.hSync) hs_low++;
        if (ras_a.pix_en) pe_cnt++;
        if (ras_a.bright) br_cnt++;
      end
    end
    check_val("a_hsync_low_clks", 32'(hs_low), 32'd384);
    check_val("a_pix_en_per_line", 32'(pe_cnt), 32'd800);
    check_val("a_bright_in_vblank", 32'(br_cnt), 32'd0);

    // Small instance: window edges, frames, frame_tick spacing.
    rst_b = 1'b0;
    pe_cnt = 0;
    vs_low = 0;
    ft_cnt = 0;
    ft_first = -1;
    ft_last = -1;
    for (int k = 1; k <= 1360; k++) begin
      tick();
      case (k)
        1:    check_val("b_pix_en_first", 32'(ras_b.pix_en), 32'd1);
        2:    check_val("b_pix_en_gap", 32'(ras_b.pix_en), 32'd0);
        4:    check_b("b_h2", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        6:    check_b("b_h3", 3, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        32:   check_b("b_line1", 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        62:   check_b("b_15_1", 15, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        64:   check_b("b_0_2", 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        104:  check_b("b_4_3", 4, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        106:  check_b("b_5_3", 5, 3, 1'b1, 1'b1, 1'b1, 1'b0);
        314:  check_b("b_13_9", 13, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        316:  check_b("b_14_9", 14, 9, 1'b1, 1'b1, 1'b0, 1'b0);
        320:  check_b("b_0_10", 0, 10, 1'b0, 1'b1, 1'b0, 1'b1);
        321:  check_b("b_0_10_next", 0, 10, 1'b0, 1'b1, 1'b0, 1'b0);
        330:  check_b("b_5_10", 5, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        384:  check_b("b_frame_wrap", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        1360: check_b("b_pre_reset", 8, 6, 1'b1, 1'b1, 1'b1, 1'b0);
        default: ;
      endcase
      if (ras_b.pix_en) pe_cnt++;
      if (k >= 384 && k <= 767 && !ras_b.vSync) vs_low++;
      if (ras_b.frame_tick) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = k;
        else check_val("b_ft_spacing", 32'(k - ft_last), 32'd384);
        ft_last = k;
      end
    end
    check_val("b_pix_en_count", 32'(pe_cnt), 32'd680);
    check_val("b_vsync_low_clks", 32'(vs_low), 32'd64);
    check_val("b_ft_count", 32'(ft_cnt), 32'd3);
    check_val("b_ft_first", 32'(ft_first), 32'd320);

    // One-clk reset mid-frame at (8, 6): raster restarts, aborted frame gets no tick.
    rst_b = 1'b1;
    tick();
    check_b("b_mid_rst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("b_mid_rst_pix_en", 32'(ras_b.pix_en), 32'd0);
    rst_b = 1'b0;
    ft_cnt = 0;
    ft_first = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (ras_b.frame_tick) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = k;
      end
      if (k == 2) check_b("b_restart", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_val("b_post_rst_ft_count", 32'(ft_cnt), 32'd1);
    check_val("b_post_rst_ft_first", 32'(ft_first), 32'd320);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
